// File: rtl/dmem_block_responder_if.sv
// rtl/dmem_block_responder_if.sv - data-cache to block memory request/response bundle
`ifndef DMEM_BLOCK_ADDR_SIZE
`define DMEM_BLOCK_ADDR_SIZE 16
`endif
`ifndef DBLOCK_SIZE_BITS
`define DBLOCK_SIZE_BITS 128
`endif

interface dmem_block_responder_if;
  logic                             memRen;
  logic                             memWen;
  logic [`DMEM_BLOCK_ADDR_SIZE-1:0] BlockAddr;
  logic [`DBLOCK_SIZE_BITS-1:0]     memDin;
  logic                             memReadReady;
  logic                             memWriteDone;
  logic [`DBLOCK_SIZE_BITS-1:0]     memDout;

  modport master (
    output memRen, memWen, BlockAddr, memDin,
    input  memReadReady, memWriteDone, memDout
  );

  modport slave (
    input  memRen, memWen, BlockAddr, memDin,
    output memReadReady, memWriteDone, memDout
  );
endinterface

// File: rtl/dmem_block_responder.sv
// rtl/dmem_block_responder.sv - fixed-latency block memory with four-phase read/write handshakes
`ifndef DMEM_BLOCK_ADDR_SIZE
`define DMEM_BLOCK_ADDR_SIZE 16
`endif
`ifndef DBLOCK_SIZE_BITS
`define DBLOCK_SIZE_BITS 128
`endif

module dmem_block_responder #(
  parameter int READ_LATENCY  = 10,
  parameter int WRITE_LATENCY = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  dmem_block_responder_if.slave  mem
);

  localparam int DEPTH = 1 << `DMEM_BLOCK_ADDR_SIZE;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_WAIT = 3'd1;
  localparam logic [2:0] WR_WAIT = 3'd2;
  localparam logic [2:0] RD_DONE = 3'd3;
  localparam logic [2:0] WR_DONE = 3'd4;

  localparam logic [7:0] RD_LOAD = 8'(READ_LATENCY - 1);
  localparam logic [7:0] WR_LOAD = 8'(WRITE_LATENCY - 1);

  logic [`DBLOCK_SIZE_BITS-1:0]     storage [DEPTH];

  logic [2:0]                       state;
  logic [7:0]                       count;
  logic [`DMEM_BLOCK_ADDR_SIZE-1:0] addrLatched;
  logic [`DBLOCK_SIZE_BITS-1:0]     dataLatched;
  logic                             readReady;
  logic                             writeDone;
  logic [`DBLOCK_SIZE_BITS-1:0]     doutReg;
  logic                             commitNow;

  // Commit is gated by reset so an aborted write never reaches storage.
  assign commitNow = reset && (state == WR_WAIT) && (count == 8'd0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= 8'd0;
      readReady <= 1'b0;
      writeDone <= 1'b0;
      doutReg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem.memWen) begin
            addrLatched <= mem.BlockAddr;
            dataLatched <= mem.memDin;
            count       <= WR_LOAD;
            state       <= WR_WAIT;
          end else if (mem.memRen) begin
            addrLatched <= mem.BlockAddr;
            count       <= RD_LOAD;
            state       <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (count == 8'd0) begin
            doutReg   <= storage[addrLatched];
            readReady <= 1'b1;
            state     <= RD_DONE;
          end else begin
            count <= count - 8'd1;
          end
        end
        WR_WAIT: begin
          if (count == 8'd0) begin
            writeDone <= 1'b1;
            state     <= WR_DONE;
          end else begin
            count <= count - 8'd1;
          end
        end
        // Release goes straight to IDLE, so the next request waits one more edge.
        RD_DONE: begin
          if (!mem.memRen) begin
            readReady <= 1'b0;
            state     <= IDLE;
          end
        end
        WR_DONE: begin
          if (!mem.memWen) begin
            writeDone <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          count     <= 8'd0;
          readReady <= 1'b0;
          writeDone <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (commitNow) begin
      storage[addrLatched] <= dataLatched;
    end
  end

  assign mem.memReadReady = readReady;
  assign mem.memWriteDone = writeDone;
  assign mem.memDout      = doutReg;

endmodule

// File: tb/tb_dmem_block_responder.sv
// tb/tb_dmem_block_responder.sv - randomized directed bench with an associative-array memory model
module tb_dmem_block_responder;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dmem_block_responder_if busA();
  dmem_block_responder_if busB();

  dmem_block_responder dutA (
    .clock (clock),
    .reset (reset),
    .mem   (busA)
  );

  dmem_block_responder #(.READ_LATENCY(1), .WRITE_LATENCY(255)) dutB (
    .clock (clock),
    .reset (reset),
    .mem   (busB)
  );

  int checks = 0;
  int errors = 0;
  logic [127:0] model [logic [15:0]];
  logic [127:0] lastRead;
  logic [15:0]  pool [4];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clock) begin
    if (reset === 1'b1) begin
      check("exclusiveA", 128'(busA.memReadReady & busA.memWriteDone), 128'd0);
      check("exclusiveB", 128'(busB.memReadReady & busB.memWriteDone), 128'd0);
    end
  end

  task automatic writeA(input logic [15:0] a, input logic [127:0] d, input int hold, input string tag);
    int cnt;
    busA.memWen = 1'b1;
    busA.BlockAddr = a;
    busA.memDin = d;
    step();
    busA.BlockAddr = 16'($urandom);
    busA.memDin = rnd();
    cnt = 0;
    while (busA.memWriteDone !== 1'b1 && cnt < 300) begin
      step();
      cnt++;
    end
    check({tag, "_lat"}, 128'(cnt), 128'd10);
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold"}, 128'(busA.memWriteDone), 128'd1);
    end
    busA.memWen = 1'b0;
    step();
    check({tag, "_release"}, 128'(busA.memWriteDone), 128'd0);
    check({tag, "_doutKept"}, busA.memDout, lastRead);
    model[a] = d;
  endtask

  task automatic readA(input logic [15:0] a, input int hold, input int dropAfter, input string tag);
    int cnt;
    logic [127:0] exp;
    exp = model[a];
    busA.memRen = 1'b1;
    busA.BlockAddr = a;
    step();
    busA.BlockAddr = 16'($urandom);
    cnt = 0;
    while (busA.memReadReady !== 1'b1 && cnt < 300) begin
      if (dropAfter > 0 && cnt == dropAfter) busA.memRen = 1'b0;
      step();
      cnt++;
    end
    check({tag, "_lat"}, 128'(cnt), 128'd10);
    check({tag, "_data"}, busA.memDout, exp);
    lastRead = exp;
    if (dropAfter > 0) begin
      step();
      check({tag, "_oneCycle"}, 128'(busA.memReadReady), 128'd0);
    end else begin
      for (int i = 0; i < hold; i++) begin
        step();
        check({tag, "_hold"}, 128'(busA.memReadReady), 128'd1);
      end
      busA.memRen = 1'b0;
      step();
      check({tag, "_release"}, 128'(busA.memReadReady), 128'd0);
    end
    check({tag, "_doutKept"}, busA.memDout, exp);
  endtask

  initial begin
    int cnt;
    int seen;
    logic [127:0] d;
    logic [127:0] d1;
    logic [127:0] d2;

    lastRead = '0;
    reset = 1'b0;
    busA.memRen = 1'b1;
    busA.memWen = 1'b1;
    busA.BlockAddr = 16'h0005;
    busA.memDin = rnd();
    busB.memRen = 1'b1;
    busB.memWen = 1'b0;
    busB.BlockAddr = 16'h0005;
    busB.memDin = '0;
    repeat (3) step();
    check("rstReadyA", 128'(busA.memReadReady), 128'd0);
    check("rstDoneA", 128'(busA.memWriteDone), 128'd0);
    check("rstDoutA", busA.memDout, 128'd0);
    check("rstReadyB", 128'(busB.memReadReady), 128'd0);
    check("rstDoutB", busB.memDout, 128'd0);
    busA.memRen = 1'b0;
    busB.memRen = 1'b0;

    // Write request already high when reset lifts is accepted at the first edge.
    reset = 1'b1;
    writeA(16'h0041, {8'hAA, 120'd0}, 0, "wr41");
    readA(16'h0041, 10, 0, "rd41");

    // Simultaneous request: write first, then read one edge after done falls.
    d = rnd();
    busA.memRen = 1'b1;
    busA.memWen = 1'b1;
    busA.BlockAddr = 16'h00F0;
    busA.memDin = d;
    step();
    cnt = 0;
    while (busA.memWriteDone !== 1'b1 && cnt < 300) begin
      step();
      cnt++;
    end
    check("simWrLat", 128'(cnt), 128'd10);
    check("simNoReady", 128'(busA.memReadReady), 128'd0);
    busA.memWen = 1'b0;
    step();
    check("simDoneFall", 128'(busA.memWriteDone), 128'd0);
    check("simNoReadYet", 128'(busA.memReadReady), 128'd0);
    cnt = 0;
    while (busA.memReadReady !== 1'b1 && cnt < 300) begin
      step();
      cnt++;
    end
    check("simRdLat", 128'(cnt), 128'd11);
    check("simRdData", busA.memDout, d);
    busA.memRen = 1'b0;
    step();
    check("simRdRelease", 128'(busA.memReadReady), 128'd0);
    model[16'h00F0] = d;
    lastRead = d;

    readA(16'h00F0, 0, 3, "drop");

    // Reset five cycles into a write must abort it.
    d1 = rnd();
    writeA(16'h0120, d1, 1, "wr120");
    d2 = rnd();
    busA.memWen = 1'b1;
    busA.BlockAddr = 16'h0120;
    busA.memDin = d2;
    step();
    repeat (4) step();
    reset = 1'b0;
    busA.memWen = 1'b0;
    step();
    check("abortDone", 128'(busA.memWriteDone), 128'd0);
    check("abortReady", 128'(busA.memReadReady), 128'd0);
    check("abortDout", busA.memDout, 128'd0);
    reset = 1'b1;
    lastRead = '0;
    seen = 0;
    repeat (15) begin
      step();
      if (busA.memWriteDone === 1'b1) seen++;
    end
    check("abortNoDone", 128'(seen), 128'd0);
    readA(16'h0120, 0, 0, "rd120");

    for (int i = 0; i < 4; i++) begin
      pool[i] = 16'($urandom) | 16'h8000;
      writeA(pool[i], rnd(), int'($urandom_range(0, 3)), "rndWrInit");
    end
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 1)
        writeA(pool[$urandom_range(0, 3)], rnd(), int'($urandom_range(0, 3)), "rndWr");
      else if ($urandom_range(0, 1) == 1)
        readA(pool[$urandom_range(0, 3)], int'($urandom_range(0, 4)), 0, "rndRd");
      else
        readA(pool[$urandom_range(0, 3)], 0, int'($urandom_range(1, 8)), "rndDrop");
    end

    // Extreme latencies on the second instance.
    d = rnd();
    busB.memWen = 1'b1;
    busB.BlockAddr = 16'h0333;
    busB.memDin = d;
    step();
    cnt = 0;
    while (busB.memWriteDone !== 1'b1 && cnt < 300) begin
      step();
      cnt++;
    end
    check("bWrLat", 128'(cnt), 128'd255);
    busB.memWen = 1'b0;
    step();
    check("bWrRelease", 128'(busB.memWriteDone), 128'd0);
    busB.memRen = 1'b1;
    step();
    cnt = 0;
    while (busB.memReadReady !== 1'b1 && cnt < 300) begin
      step();
      cnt++;
    end
    check("bRdLat", 128'(cnt), 128'd1);
    check("bRdData", busB.memDout, d);
    busB.memRen = 1'b0;
    step();
    check("bRdRelease", 128'(busB.memReadReady), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_block_responder.md
DMEM_BLOCK_RESPONDER -- requirements
Module: dmem_block_responder

Interface
REQ-001 Parameter READ_LATENCY, default 10: cycles from request acceptance to memReadReady rising; legal range 1..255.
REQ-002 Parameter WRITE_LATENCY, default 10: cycles from request acceptance to memWriteDone rising; legal range 1..255.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 memRen  input  1  block read request from the data-cache controller; level, held until memReadReady seen.
REQ-006 memWen  input  1  block write-back request from the data-cache controller; level, held until memWriteDone seen.
REQ-007 BlockAddr  input  `DMEM_BLOCK_ADDR_SIZE (16)  block address, shared by read and write.
REQ-008 memDin  input  `DBLOCK_SIZE_BITS (128)  write-back block data.
REQ-009 memReadReady  output  1  read complete; memDout valid while high.
REQ-010 memWriteDone  output  1  write committed to storage.
REQ-011 memDout  output  `DBLOCK_SIZE_BITS (128)  read block data, registered.

Function
REQ-012 Storage SHALL be 2^`DMEM_BLOCK_ADDR_SIZE entries of `DBLOCK_SIZE_BITS bits, whole-block access only.
REQ-013 FSM states SHALL be IDLE, RD_WAIT, WR_WAIT, RD_DONE, WR_DONE.
REQ-014 IDLE: memWen high at a rising edge -> latch BlockAddr and memDin, load counter with WRITE_LATENCY-1, go to WR_WAIT.
REQ-015 IDLE: memRen high with memWen low -> latch BlockAddr, load counter with READ_LATENCY-1, go to RD_WAIT.
REQ-016 memRen and memWen both high in IDLE: write SHALL win; the read is accepted only after the write handshake completes.
REQ-017 Request inputs SHALL be ignored outside IDLE; latched address/data SHALL NOT follow input changes.
REQ-018 RD_WAIT/WR_WAIT: counter decrements each cycle; at the edge where the counter is 0, transition to RD_DONE/WR_DONE.
REQ-019 Latency: request sampled at edge N -> memReadReady/memWriteDone high after edge N+LATENCY.
REQ-020 WR_WAIT -> WR_DONE edge SHALL write latched memDin to latched address and set memWriteDone.
REQ-021 RD_WAIT -> RD_DONE edge SHALL load memDout from the array at the latched address and set memReadReady.
REQ-022 Read of an address written by a prior completed write SHALL return the written data.
REQ-023 RD_DONE: memReadReady stays high while memRen is high; the first edge sampling memRen low clears memReadReady and returns to IDLE.
REQ-024 WR_DONE: same four-phase release on memWen and memWriteDone.
REQ-025 Request dropped during RD_WAIT: operation SHALL still finish; RD_DONE then lasts exactly one cycle.
REQ-026 Request dropped during WR_WAIT: the write SHALL still commit; WR_DONE then lasts exactly one cycle.
REQ-027 memDout SHALL hold its last read value outside RD_DONE; writes SHALL NOT alter memDout.
REQ-028 memReadReady and memWriteDone SHALL never be high together.
REQ-029 A new request SHALL NOT be accepted in the cycle memReadReady or memWriteDone falls; earliest acceptance is the following edge.

Reset
REQ-030 reset low at a rising edge: state IDLE, counter 0, memReadReady 0, memWriteDone 0, memDout 0.
REQ-031 Reset SHALL override any in-flight operation; a write not yet at its commit edge SHALL NOT be committed.
REQ-032 Storage contents SHALL NOT be cleared by reset.
REQ-033 Requests high while reset is low SHALL be ignored; acceptance starts at the first edge with reset high.

Verification
REQ-034 Write then read: memWen, BlockAddr 0x0041, memDin 0xAA followed by 120 zero bits, default latency -> memWriteDone high 10 cycles after acceptance. Then memRen to 0x0041 -> memReadReady after 10 cycles with memDout equal to the written value.
REQ-035 Four-phase hold: memRen held 10 cycles after memReadReady -> memReadReady stays high throughout and clears on the edge after memRen falls. No second read is issued.
REQ-036 Simultaneous request: memRen and memWen both high to 0x00F0 -> write completes first; the read then returns the new data. The two done signals are never high together.
REQ-037 Early drop: memRen drops 3 cycles after acceptance -> memReadReady high for exactly one cycle at the normal latency, then IDLE.
REQ-038 Reset mid-write: reset low 5 cycles into a write to 0x0120 -> outputs 0, no memWriteDone. A later read of 0x0120 returns the pre-write contents.
REQ-039 Latency parameters: READ_LATENCY=1, WRITE_LATENCY=255 -> ready after 1 cycle and done after 255 cycles respectively.
